pcileech_tlp_tx_arbiter: RTL
============================

# pcileech_tlp_tx_arbiter

Round-robin scheduler that shares the single 64-bit transmit stream into the PCIe core between up to four TLP sources (FIFO-injected TLPs, static/config TLPs, internally generated completions, spare). Packets are locked per grant: once a port wins, all its beats pass contiguously until `last`, then arbitration restarts. It sits between the TLP generators and `tlp_tx` in the PCIe clock domain. It adds a registered output stage and oversize-TLP detection.

## Interface
- `NPORTS`, 4: number of source ports, 1..4.
- `MAX_BEATS`, 18: maximum legal 64-bit beats per TLP; beat counter width is $clog2(MAX_BEATS+1).
- `clk`  in  1  PCIe user clock (62.5 MHz); all logic on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low. Deassertion is externally synchronised.
- `src_data`  in  64×NPORTS  per-port beat data; bits [31:0] hold the first DWORD.
- `src_keep`  in  8×NPORTS  per-port byte keep; only 8'h0f and 8'hff are legal.
- `src_last`  in  NPORTS  per-port end-of-TLP.
- `src_valid`  in  NPORTS  per-port beat valid.
- `src_ready`  out  NPORTS  per-port beat accept.
- `port_en`  in  NPORTS  per-port enable. Gates new grants only.
- `tx_data`  out  64  to core.
- `tx_keep`  out  8  to core.
- `tx_last`  out  1  to core.
- `tx_valid`  out  1  to core.
- `tx_ready`  in  1  from core.
- `grant`  out  NPORTS  one-hot current owner; 0 when idle.
- `err_oversize`  out  1  one-cycle pulse when the owner exceeds MAX_BEATS without `last`.

## Operation
- States:
  - IDLE: no owner; `grant`=0; all `src_ready`=0.
  - XFER: one owner.
- IDLE→XFER when any port has `src_valid & port_en`.
  - Winner is the first such port scanning upward from (last owner+1) mod NPORTS.
  - After reset, the last owner is port NPORTS-1, so port 0 has first priority.
- In XFER:
  - `src_ready[g]` = skid-buffer-can-accept; every other `src_ready` = 0.
  - A beat is accepted when `src_valid[g] & src_ready[g]`.
  - The beat counter increments per accepted beat.
- XFER→IDLE on an accepted beat with `src_last`. The last-owner pointer is updated at the same time.
- Deasserting `port_en[g]` mid-packet does not abort the packet; the TLP completes.
- Oversize: an accepted beat with the counter already at MAX_BEATS and no `last`:
  - pulses `err_oversize`;
  - the counter saturates;
  - the packet continues until `last` (no truncation).
- The owner may hold `src_valid` low mid-packet. The grant is held and the output bubbles.
- Output stage is a 2-entry skid buffer:
  - `tx_*` are driven from registers.
  - `tx_valid` is never combinationally dependent on `tx_ready`.
  - Data is held stable while `tx_valid & ~tx_ready`.

## Timing
- Reset values:
  - `tx_valid`, `tx_last`, `tx_data`, `tx_keep`, `grant`, `src_ready`, `err_oversize` = 0;
  - state IDLE; beat counter 0; last owner NPORTS-1.
- Arbitration costs 1 cycle: a request seen in IDLE in cycle N gives `grant` valid in N+1. The first beat can be accepted in N+1.
- Latency: a beat accepted in cycle N appears on `tx_*` in N+1 if the buffer is empty.
- Throughput:
  - 1 beat/cycle within a packet while `tx_ready` is high.
  - One IDLE bubble between consecutive packets, including same-port back-to-back packets.
- Skid buffer full (2 entries pending) forces `src_ready`=0. It reopens the cycle after `tx_ready` drains one entry.
- A single-beat TLP (`last` on the first beat) is legal: XFER lasts 1 accepted beat.
- `rst_n` low mid-packet:
  - all state clears immediately;
  - the partial TLP is dropped;
  - the source must restart from its header after reset.

## Configuration
- `PCILEECH_TLPARB_STATS_EN` defined:
  - adds output `stat_tlp_cnt` (32×NPORTS), one wrapping 32-bit count of completed TLPs per port;
  - adds output `stat_ovf_cnt` (16 bits), a saturating count of `err_oversize` pulses;
  - both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package `pcileech_tlparb_pkg` holds:
  - state enum `tlparb_state_t` {IDLE, XFER};
  - constants KEEP_LO=8'h0f and KEEP_FULL=8'hff;
  - the round-robin pick function `rr_pick(req, last)`.
- Sub-module `tlp64_skid_buffer`: a 2-entry AXI-S register slice carrying data/keep/last, using the same clk/rst_n.

## Test plan
- **Single port:** port 0 sends 3 beats, `tx_ready`=1.
  - `grant`=4'b0001 one cycle after request.
  - 3 beats appear on `tx_*` in order, `last` on the third.
  - Then IDLE.
- **Round-robin:** ports 0, 1, 2 request continuously with 2-beat TLPs.
  - Grant order 0,1,2,0,1,2.
  - One idle cycle between packets.
- **Enable gating:** clear `port_en[1]` mid-packet on port 1.
  - That packet completes.
  - Port 1 is not granted again while `port_en[1]`=0.
- **Backpressure:** `tx_ready` low for 5 cycles mid-packet.
  - `tx_data` is stable throughout.
  - `src_ready` drops after 2 buffered beats.
  - No beat is lost or duplicated.
- **Oversize:** port 3 sends 19 beats without `last`, then a `last` beat.
  - `err_oversize` pulses once on beat 19.
  - All 20 beats are forwarded.
- **Reset mid-packet:** `rst_n` low during beat 2 of 4.
  - All outputs go to 0 asynchronously.
  - After release, port 0 has priority.

Source files
------------

// File: rtl/pcileech_tlparb_pkg.sv
// pcileech_tlparb_pkg: shared types, keep constants and round-robin pick for the TLP TX arbiter.
package pcileech_tlparb_pkg;

    typedef enum logic {IDLE, XFER} tlparb_state_t;

    localparam logic [7:0] KEEP_LO   = 8'h0f;
    localparam logic [7:0] KEEP_FULL = 8'hff;

    // Index of the first requester scanning upward from last+1; unused high bits of req must be 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/tlp64_skid_buffer.sv
// tlp64_skid_buffer: 2-entry AXI-S register slice for 64-bit TLP beats (data/keep/last).
module tlp64_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [63:0] up_data,
    input  logic [7:0]  up_keep,
    input  logic        up_last,
    output logic        dn_valid,
    input  logic        dn_ready,
    output logic [63:0] dn_data,
    output logic [7:0]  dn_keep,
    output logic        dn_last
);

    logic [72:0] o_q, s_q;
    logic        o_v, s_v, push, pop;

    assign up_ready = ~s_v;
    assign push     = up_valid & up_ready;
    assign pop      = o_v & dn_ready;
    assign dn_valid = o_v;
    assign {dn_keep, dn_last, dn_data} = o_q;

    // The skid entry only fills while the output is stalled, so push and s_v are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
            s_q <= '0;
            o_v <= 1'b0;
            s_v <= 1'b0;
        end else if (pop | ~o_v) begin
            o_v <= s_v | push;
            o_q <= s_v ? s_q : (push ? {up_keep, up_last, up_data} : o_q);
            s_v <= 1'b0;
        end else if (push) begin
            s_q <= {up_keep, up_last, up_data};
            s_v <= 1'b1;
        end
    end

endmodule

// File: rtl/pcileech_tlp_tx_arbiter.sv
// pcileech_tlp_tx_arbiter: packet-locked round-robin merge of up to 4 TLP sources onto one 64-bit stream.
// Optional per-port TLP and oversize statistics when PCILEECH_TLPARB_STATS_EN is defined.
module pcileech_tlp_tx_arbiter
    import pcileech_tlparb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int MAX_BEATS = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [64*NPORTS-1:0]   src_data,
    input  logic [8*NPORTS-1:0]    src_keep,
    input  logic [NPORTS-1:0]      src_last,
    input  logic [NPORTS-1:0]      src_valid,
    output logic [NPORTS-1:0]      src_ready,
    input  logic [NPORTS-1:0]      port_en,
    output logic [63:0]            tx_data,
    output logic [7:0]             tx_keep,
    output logic                   tx_last,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NPORTS-1:0]      grant,
`ifdef PCILEECH_TLPARB_STATS_EN
    output logic [32*NPORTS-1:0]   stat_tlp_cnt,
    output logic [15:0]            stat_ovf_cnt,
`endif
    output logic                   err_oversize
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    tlparb_state_t   state_q, state_d;
    logic [1:0]      owner_q, owner_d, last_q;
    logic [CW-1:0]   cnt_q;
    logic [NPORTS-1:0] req;
    logic [63:0]     up_data;
    logic [7:0]      up_keep;
    logic            up_valid, up_ready, up_last, acc, ovf;

    assign req      = src_valid & port_en;
    assign up_valid = (state_q == XFER) & src_valid[owner_q];
    assign up_data  = src_data[64*owner_q +: 64];
    assign up_keep  = (src_keep[8*owner_q +: 8] == KEEP_LO) ? KEEP_LO : KEEP_FULL;
    assign up_last  = src_last[owner_q];
    assign acc      = up_valid & up_ready;
    assign ovf      = acc & ~up_last & (cnt_q == CW'(MAX_BEATS));
    assign src_ready = grant & {NPORTS{up_ready}};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant   = '0;
        if (state_q == IDLE) begin
            state_d = |req ? XFER : IDLE;
            owner_d = |req ? rr_pick(4'(req), last_q) : owner_q;
        end else begin
            grant[owner_q] = 1'b1;
            state_d = (acc & up_last) ? IDLE : XFER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= 2'(NPORTS - 1);
            cnt_q        <= '0;
            err_oversize <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            err_oversize <= ovf;
            if (acc) begin
                cnt_q <= up_last ? '0 : ((cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + 1'b1);
                if (up_last) last_q <= owner_q;
            end
        end
    end

`ifdef PCILEECH_TLPARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tlp_cnt <= '0;
            stat_ovf_cnt <= '0;
        end else begin
            if (acc & up_last) stat_tlp_cnt[32*owner_q +: 32] <= stat_tlp_cnt[32*owner_q +: 32] + 32'd1;
            if (ovf & ~&stat_ovf_cnt) stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
        end
    end
`endif

    tlp64_skid_buffer u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .up_keep  (up_keep),
        .up_last  (up_last),
        .dn_valid (tx_valid),
        .dn_ready (tx_ready),
        .dn_data  (tx_data),
        .dn_keep  (tx_keep),
        .dn_last  (tx_last)
    );

endmodule
